// File: rtl/rpe_pkg.sv
// Shared definitions for the RPE array sequencer.
// - SIZE / PARTIAL_SUM_WIDTH: array geometry shared with the datapath.
// - rpe_state_e: sequencer FSM states.
package rpe_pkg;

  localparam int unsigned SIZE              = 8;
  localparam int unsigned PARTIAL_SUM_WIDTH = 32;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoadW   = 3'd1,
    StCompute = 3'd2,
    StDrain   = 3'd3,
    StDone    = 3'd4
  } rpe_state_e;

endpackage

// File: rtl/rpe_valid_delay.sv
// Fixed-depth delay line for 1-bit valid tags.
// - clk_i / rst_ni : clock, asynchronous active-low reset
// - flush_i        : synchronous clear of every stage
// - valid_i        : tag entering the line
// - valid_o        : tag delayed by DEPTH cycles (registered)
// - any_valid_o    : some tag is still in flight behind the output stage
module rpe_valid_delay #(
  parameter int unsigned DEPTH = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic valid_i,
  output logic valid_o,
  output logic any_valid_o
);

  logic [DEPTH-1:0] pipe_q, pipe_d;

  always_comb begin
    pipe_d = '0;
    if (!flush_i) begin
      pipe_d = {pipe_q[DEPTH-2:0], valid_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign valid_o     = pipe_q[DEPTH-1];
  // Excludes the output stage: when this is low and valid_o is high, that write is the last.
  assign any_valid_o = |pipe_q[DEPTH-2:0];

endmodule

// File: rtl/rpe_array_seq_ctrl.sv
// Sequencer for one weight-stationary tile on a SIZExSIZE RPE array.
// Loads SIZE weight rows (bottom row first), streams n activation vectors,
// and tags the deskewed results for the output buffer.
// Ports:
// - clk, rst_n            : clock, asynchronous active-low reset
// - start, abort, num_vec : tile start pulse, synchronous abort, vector count
// - busy, done            : tile in progress, one-cycle completion pulse
// - w_rd_en/w_rd_addr     : weight buffer read port
// - weight_valid          : array row-0 weight valid
// - a_rd_en/a_rd_addr     : activation buffer read port
// - o_wr_en/o_wr_addr     : output buffer write port
module rpe_array_seq_ctrl #(
  parameter int unsigned SIZE     = rpe_pkg::SIZE,
  parameter int unsigned MAX_VEC  = 256,
  parameter int unsigned W_ADDR_W = $clog2(SIZE),
  parameter int unsigned A_ADDR_W = $clog2(MAX_VEC),
  parameter int unsigned OUT_LAT  = 2 * SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [A_ADDR_W:0]   num_vec,
  output logic                busy,
  output logic                done,
  output logic                w_rd_en,
  output logic [W_ADDR_W-1:0] w_rd_addr,
  output logic                weight_valid,
  output logic                a_rd_en,
  output logic [A_ADDR_W-1:0] a_rd_addr,
  output logic                o_wr_en,
  output logic [A_ADDR_W-1:0] o_wr_addr
);

  import rpe_pkg::*;

  localparam logic [A_ADDR_W:0] MaxVec = (A_ADDR_W + 1)'(MAX_VEC);

  rpe_state_e          state_q, state_d;
  logic [A_ADDR_W:0]   n_q, n_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                w_rd_en_q, w_rd_en_d, weight_valid_q, weight_valid_d;
  logic                a_rd_en_q, a_rd_en_d;
  logic [W_ADDR_W-1:0] w_rd_addr_q, w_rd_addr_d;
  logic [A_ADDR_W-1:0] a_rd_addr_q, a_rd_addr_d;
  logic [A_ADDR_W:0]   n_sat;
  logic                flush, dly_out, dly_pending;

  assign n_sat = (num_vec > MaxVec) ? MaxVec : num_vec;

  always_comb begin
    state_d        = state_q;
    n_d            = n_q;
    rd_cnt_d       = rd_cnt_q;
    wr_cnt_d       = wr_cnt_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    w_rd_en_d      = 1'b0;
    w_rd_addr_d    = w_rd_addr_q;
    weight_valid_d = w_rd_en_q;
    a_rd_en_d      = 1'b0;
    a_rd_addr_d    = a_rd_addr_q;
    flush          = 1'b0;

    if (dly_out) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          n_d    = n_sat;
          busy_d = 1'b1;
          if (n_sat == '0) begin
            state_d = StDone;
          end else begin
            state_d     = StLoadW;
            w_rd_en_d   = 1'b1;
            w_rd_addr_d = W_ADDR_W'(SIZE - 1);
          end
        end
      end
      StLoadW: begin
        if (w_rd_addr_q == '0) begin
          state_d = StCompute;
        end else begin
          w_rd_en_d   = 1'b1;
          w_rd_addr_d = w_rd_addr_q - 1'b1;
        end
      end
      StCompute: begin
        if (rd_cnt_q == n_q) begin
          state_d = StDrain;
        end else begin
          a_rd_en_d   = 1'b1;
          a_rd_addr_d = rd_cnt_q[A_ADDR_W-1:0];
          rd_cnt_d    = rd_cnt_q + 1'b1;
        end
      end
      StDrain: begin
        // Reads are back-to-back, so the line drains with no gaps.
        if (dly_out && !dly_pending) begin
          state_d = StDone;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      StDone: begin
        // done_q low only on the n==0 path, which needs one extra cycle before the pulse.
        if (done_q) begin
          state_d     = StIdle;
          n_d         = '0;
          rd_cnt_d    = '0;
          wr_cnt_d    = '0;
          w_rd_addr_d = '0;
          a_rd_addr_d = '0;
        end else begin
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d        = StIdle;
      n_d            = '0;
      rd_cnt_d       = '0;
      wr_cnt_d       = '0;
      busy_d         = 1'b0;
      done_d         = 1'b0;
      w_rd_en_d      = 1'b0;
      w_rd_addr_d    = '0;
      weight_valid_d = 1'b0;
      a_rd_en_d      = 1'b0;
      a_rd_addr_d    = '0;
      flush          = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      n_q            <= '0;
      rd_cnt_q       <= '0;
      wr_cnt_q       <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      w_rd_en_q      <= 1'b0;
      w_rd_addr_q    <= '0;
      weight_valid_q <= 1'b0;
      a_rd_en_q      <= 1'b0;
      a_rd_addr_q    <= '0;
    end else begin
      state_q        <= state_d;
      n_q            <= n_d;
      rd_cnt_q       <= rd_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      w_rd_en_q      <= w_rd_en_d;
      w_rd_addr_q    <= w_rd_addr_d;
      weight_valid_q <= weight_valid_d;
      a_rd_en_q      <= a_rd_en_d;
      a_rd_addr_q    <= a_rd_addr_d;
    end
  end

  rpe_valid_delay #(
    .DEPTH(OUT_LAT)
  ) u_valid_delay (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .flush_i    (flush),
    .valid_i    (a_rd_en_q),
    .valid_o    (dly_out),
    .any_valid_o(dly_pending)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign w_rd_en      = w_rd_en_q;
  assign w_rd_addr    = w_rd_addr_q;
  assign weight_valid = weight_valid_q;
  assign a_rd_en      = a_rd_en_q;
  assign a_rd_addr    = a_rd_addr_q;
  assign o_wr_en      = dly_out;
  assign o_wr_addr    = wr_cnt_q[A_ADDR_W-1:0];

endmodule

// File: tb/tb_rpe_array_seq_ctrl.sv
// Bench for rpe_array_seq_ctrl with SIZE=4, OUT_LAT=8, MAX_VEC=256.
// Cycle k = interval just before clock edge k; start in cycle 0 is sampled by edge 0.
module tb_rpe_array_seq_ctrl;

  localparam int unsigned SIZE    = 4;
  localparam int unsigned MAX_VEC = 256;
  localparam int unsigned OUT_LAT = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [8:0] num_vec = '0;
  logic       busy, done, w_rd_en, weight_valid, a_rd_en, o_wr_en;
  logic [1:0] w_rd_addr;
  logic [7:0] a_rd_addr, o_wr_addr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic       start;
    logic [8:0] num_vec;
    logic       busy;
    logic       done;
    logic       w_en;
    logic [1:0] w_addr;
    logic       wv;
    logic       a_en;
    logic [7:0] a_addr;
    logic       o_en;
    logic [7:0] o_addr;
  } vec_t;

  vec_t tbl [19];

  rpe_array_seq_ctrl #(
    .SIZE   (SIZE),
    .MAX_VEC(MAX_VEC),
    .OUT_LAT(OUT_LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .num_vec     (num_vec),
    .busy        (busy),
    .done        (done),
    .w_rd_en     (w_rd_en),
    .w_rd_addr   (w_rd_addr),
    .weight_valid(weight_valid),
    .a_rd_en     (a_rd_en),
    .a_rd_addr   (a_rd_addr),
    .o_wr_en     (o_wr_en),
    .o_wr_addr   (o_wr_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Control outputs only; all read/write enables expected low.
  task automatic chk_ctl(input string tag, input logic exp_busy, input logic exp_done);
    chk({tag, " busy"}, busy, exp_busy);
    chk({tag, " done"}, done, exp_done);
    chk({tag, " w_rd_en"}, w_rd_en, 0);
    chk({tag, " weight_valid"}, weight_valid, 0);
    chk({tag, " a_rd_en"}, a_rd_en, 0);
    chk({tag, " o_wr_en"}, o_wr_en, 0);
  endtask

  task automatic chk_idle(input string tag);
    chk_ctl(tag, 1'b0, 1'b0);
    chk({tag, " w_rd_addr"}, w_rd_addr, 0);
    chk({tag, " a_rd_addr"}, a_rd_addr, 0);
    chk({tag, " o_wr_addr"}, o_wr_addr, 0);
  endtask

  // Drive row rel's inputs, compare this cycle's outputs, advance one cycle.
  task automatic run_rel(input int rel, input string tag);
    string t;
    t = $sformatf("%s c%0d", tag, rel);
    start   = tbl[rel].start;
    num_vec = tbl[rel].num_vec;
    chk({t, " busy"}, busy, tbl[rel].busy);
    chk({t, " done"}, done, tbl[rel].done);
    chk({t, " w_rd_en"}, w_rd_en, tbl[rel].w_en);
    chk({t, " weight_valid"}, weight_valid, tbl[rel].wv);
    chk({t, " a_rd_en"}, a_rd_en, tbl[rel].a_en);
    chk({t, " o_wr_en"}, o_wr_en, tbl[rel].o_en);
    if (tbl[rel].w_en) chk({t, " w_rd_addr"}, w_rd_addr, tbl[rel].w_addr);
    if (tbl[rel].a_en) chk({t, " a_rd_addr"}, a_rd_addr, tbl[rel].a_addr);
    if (tbl[rel].o_en) chk({t, " o_wr_addr"}, o_wr_addr, tbl[rel].o_addr);
    step();
  endtask

  int reads, writes, order_err, done_cyc;
  logic [7:0] last_o;

  initial begin
    // Tile with num_vec=3; starts in cycles 3 and 17 (num_vec=5) must be ignored.
    for (int r = 0; r < 19; r++) begin
      tbl[r]         = '0;
      tbl[r].start   = (r == 0) || (r == 3) || (r == 17);
      tbl[r].num_vec = (r == 0) ? 9'd3 : ((r == 3) || (r == 17)) ? 9'd5 : 9'd0;
      tbl[r].busy    = (r >= 1) && (r <= 16);
      tbl[r].done    = (r == 17);
      tbl[r].w_en    = (r >= 1) && (r <= 4);
      tbl[r].w_addr  = 2'(4 - r);
      tbl[r].wv      = (r >= 2) && (r <= 5);
      tbl[r].a_en    = (r >= 6) && (r <= 8);
      tbl[r].a_addr  = 8'(r - 6);
      tbl[r].o_en    = (r >= 14) && (r <= 16);
      tbl[r].o_addr  = 8'(r - 14);
    end

    step();
    chk_idle("reset");
    step();
    rst_n = 1'b1;
    step();
    chk_idle("after reset");

    // Two tiles: the second start lands in cycle 18, right after done.
    for (int r = 0; r < 18; r++) run_rel(r, "t1");
    for (int r = 0; r < 19; r++) run_rel(r, "t2");

    // num_vec == 0
    start = 1'b1;
    num_vec = 9'd0;
    chk_ctl("n0 c0", 1'b0, 1'b0);
    step();
    start = 1'b0;
    chk_ctl("n0 c1", 1'b1, 1'b0);
    step();
    chk_ctl("n0 c2", 1'b0, 1'b1);
    step();
    chk_ctl("n0 c3", 1'b0, 1'b0);
    step();

    // Abort in cycle 7, restart in cycle 9.
    for (int r = 0; r < 7; r++) run_rel(r, "ab");
    abort = 1'b1;
    run_rel(7, "ab");
    abort = 1'b0;
    chk_idle("ab c8");
    step();
    for (int r = 0; r < 19; r++) run_rel(r, "ab_re");

    // Simultaneous start and abort in IDLE: start dropped.
    start = 1'b1;
    abort = 1'b1;
    num_vec = 9'd3;
    step();
    start = 1'b0;
    abort = 1'b0;
    num_vec = 9'd0;
    chk_ctl("sa c1", 1'b0, 1'b0);
    step();
    chk_ctl("sa c2", 1'b0, 1'b0);
    step();

    // num_vec saturates to MAX_VEC.
    start = 1'b1;
    num_vec = 9'd300;
    step();
    start = 1'b0;
    num_vec = 9'd0;
    reads = 0;
    writes = 0;
    order_err = 0;
    done_cyc = -1;
    last_o = '0;
    for (int c = 1; c < 600 && done_cyc < 0; c++) begin
      if (a_rd_en) begin
        if (a_rd_addr != 8'(reads)) order_err++;
        reads++;
      end
      if (o_wr_en) begin
        if (o_wr_addr != 8'(writes)) order_err++;
        writes++;
        last_o = o_wr_addr;
      end
      if (done) done_cyc = c;
      step();
    end
    chk("sat reads", reads, 256);
    chk("sat writes", writes, 256);
    chk("sat last o_wr_addr", last_o, 255);
    chk("sat address order errors", order_err, 0);
    chk("sat done cycle", done_cyc, SIZE + 2 + 256 + OUT_LAT);
    chk_idle("sat idle");
    step();

    // Asynchronous reset in cycle 10.
    for (int r = 0; r < 10; r++) run_rel(r, "rs");
    rst_n = 1'b0;
    #1;
    chk_idle("rs async");
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_idle("rs rel c1");
    step();
    chk_idle("rs rel c2");
    for (int r = 0; r < 19; r++) run_rel(r, "rs_re");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
